// File: rtl/mtime_tick_arb.sv
// mtime_tick_arb
//   Sits between the CPU APB path and the mtimer APB slave. Every PRESCALE
//   enabled clocks it queues a tick. It then runs an atomic read-modify-write
//   sequence on the 64-bit mtime (lo word, and hi word on carry) through the
//   downstream port. That traffic is arbitrated round-robin against forwarded
//   CPU transfers.
//
//   Ports
//     clk, rst               clock, asynchronous active-high reset
//     tick_en                prescaler runs when 1, holds its count when 0
//     s_psel .. s_pwstrb     upstream (CPU) APB request
//     s_pready/prdata/pslverr  upstream completion (one-cycle pulse)
//     m_psel .. m_pwstrb     downstream APB request to the mtimer
//     m_pready/prdata/pslverr  downstream completion
//     tick_drop              pulse: tick lost, pending counter saturated
//     tick_err               pulse: tick sequence aborted by m_pslverr
//
//   Handshake: a downstream access is one SETUP cycle (psel=1, penable=0) and
//   then ACCESS cycles (psel=1, penable=1) until m_pready=1. m_pslverr and
//   m_prdata are only looked at in that completing cycle. Upstream, a request
//   is s_psel=1 held until s_pready=1, and s_prdata/s_pslverr are valid only
//   while s_pready=1.
module mtime_tick_arb #(
   parameter int          PRESCALE   = 100,
   parameter int          PEND_W     = 4,
   parameter logic [15:0] MTIME_ADDR = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_en,
   input  logic        s_psel,
   input  logic        s_penable,
   input  logic [15:0] s_paddr,
   input  logic        s_pwrite,
   input  logic [31:0] s_pwdata,
   input  logic [3:0]  s_pwstrb,
   output logic        s_pready,
   output logic [31:0] s_prdata,
   output logic        s_pslverr,
   output logic        m_psel,
   output logic        m_penable,
   output logic [15:0] m_paddr,
   output logic        m_pwrite,
   output logic [31:0] m_pwdata,
   output logic [3:0]  m_pwstrb,
   input  logic        m_pready,
   input  logic [31:0] m_prdata,
   input  logic        m_pslverr,
   output logic        tick_drop,
   output logic        tick_err
);

   localparam int                CNT_W    = $clog2(PRESCALE);
   localparam logic [CNT_W-1:0]  PS_MAX   = CNT_W'(PRESCALE - 1);
   localparam logic [15:0]       MTIME_HI = MTIME_ADDR + 16'd4;

   typedef enum logic [3:0] {
      ST_IDLE, ST_C_SETUP, ST_C_ACCESS,
      ST_RLO_SETUP, ST_RLO_ACCESS, ST_WLO_SETUP, ST_WLO_ACCESS,
      ST_RHI_SETUP, ST_RHI_ACCESS, ST_WHI_SETUP, ST_WHI_ACCESS
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              last_tick_q, last_tick_d;   // 1 = tick sequence won the last grant
   logic              carry_q, carry_d;           // low word read back as all ones
   logic              m_psel_q, m_psel_d;
   logic              m_penable_q, m_penable_d;
   logic [15:0]       m_paddr_q, m_paddr_d;
   logic              m_pwrite_q, m_pwrite_d;
   logic [31:0]       m_pwdata_q, m_pwdata_d;
   logic [3:0]        m_pwstrb_q, m_pwstrb_d;

   logic tick, pend_sat, tck_req, grant_cpu, grant_tck;
   logic tick_access, seq_done;

   // The upstream request is taken from s_psel alone; s_penable adds nothing.
   logic unused_s_penable;
   assign unused_s_penable = s_penable;

   assign tick      = tick_en && (presc_q == PS_MAX);
   assign pend_sat  = &pend_q;
   assign tck_req   = |pend_q;
   // On contention the side that did not win last time gets the bus.
   assign grant_cpu = s_psel  && (!tck_req || last_tick_q);
   assign grant_tck = tck_req && (!s_psel  || !last_tick_q);

   assign tick_access = (state_q == ST_RLO_ACCESS) || (state_q == ST_WLO_ACCESS) ||
                        (state_q == ST_RHI_ACCESS) || (state_q == ST_WHI_ACCESS);
   // A sequence ends on an error anywhere, or on its final write.
   assign seq_done = tick_access && m_pready &&
                     (m_pslverr || (state_q == ST_WHI_ACCESS) ||
                      ((state_q == ST_WLO_ACCESS) && !carry_q));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         presc_q     <= '0;
         pend_q      <= '0;
         last_tick_q <= 1'b0;
         carry_q     <= 1'b0;
         m_psel_q    <= 1'b0;
         m_penable_q <= 1'b0;
         m_paddr_q   <= '0;
         m_pwrite_q  <= 1'b0;
         m_pwdata_q  <= '0;
         m_pwstrb_q  <= '0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         pend_q      <= pend_d;
         last_tick_q <= last_tick_d;
         carry_q     <= carry_d;
         m_psel_q    <= m_psel_d;
         m_penable_q <= m_penable_d;
         m_paddr_q   <= m_paddr_d;
         m_pwrite_q  <= m_pwrite_d;
         m_pwdata_q  <= m_pwdata_d;
         m_pwstrb_q  <= m_pwstrb_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_cpu)      state_d = ST_C_SETUP;
            else if (grant_tck) state_d = ST_RLO_SETUP;
         end
         ST_C_SETUP:    state_d = ST_C_ACCESS;
         ST_C_ACCESS:   if (m_pready) state_d = ST_IDLE;
         ST_RLO_SETUP:  state_d = ST_RLO_ACCESS;
         ST_RLO_ACCESS: if (m_pready) state_d = m_pslverr ? ST_IDLE : ST_WLO_SETUP;
         ST_WLO_SETUP:  state_d = ST_WLO_ACCESS;
         ST_WLO_ACCESS: if (m_pready) state_d = (m_pslverr || !carry_q) ? ST_IDLE : ST_RHI_SETUP;
         ST_RHI_SETUP:  state_d = ST_RHI_ACCESS;
         ST_RHI_ACCESS: if (m_pready) state_d = m_pslverr ? ST_IDLE : ST_WHI_SETUP;
         ST_WHI_SETUP:  state_d = ST_WHI_ACCESS;
         ST_WHI_ACCESS: if (m_pready) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   // Output logic: downstream bus fields are loaded on entry to each SETUP
   // and otherwise hold, so they keep their last values while m_psel=0.
   always_comb begin
      m_psel_d    = (state_d != ST_IDLE);
      m_penable_d = (state_d == ST_C_ACCESS)   || (state_d == ST_RLO_ACCESS) ||
                    (state_d == ST_WLO_ACCESS) || (state_d == ST_RHI_ACCESS) ||
                    (state_d == ST_WHI_ACCESS);
      m_paddr_d   = m_paddr_q;
      m_pwrite_d  = m_pwrite_q;
      m_pwdata_d  = m_pwdata_q;
      m_pwstrb_d  = m_pwstrb_q;
      carry_d     = carry_q;
      last_tick_d = last_tick_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_cpu) begin
               m_paddr_d   = s_paddr;
               m_pwrite_d  = s_pwrite;
               m_pwdata_d  = s_pwdata;
               m_pwstrb_d  = s_pwstrb;
               last_tick_d = 1'b0;
            end else if (grant_tck) begin
               m_paddr_d   = MTIME_ADDR;
               m_pwrite_d  = 1'b0;
               m_pwstrb_d  = 4'hF;
               last_tick_d = 1'b1;
            end
         end
         ST_RLO_ACCESS: begin
            if (m_pready && !m_pslverr) begin
               m_pwrite_d = 1'b1;
               m_pwdata_d = m_prdata + 32'd1;
               carry_d    = &m_prdata;
            end
         end
         ST_WLO_ACCESS: begin
            if (m_pready && !m_pslverr && carry_q) begin
               m_paddr_d  = MTIME_HI;
               m_pwrite_d = 1'b0;
            end
         end
         ST_RHI_ACCESS: begin
            if (m_pready && !m_pslverr) begin
               m_pwrite_d = 1'b1;
               m_pwdata_d = m_prdata + 32'd1;
            end
         end
         default: ;
      endcase
   end

   // Prescaler and pending-tick counter. A tick landing in the same cycle
   // as a sequence completion cancels out.
   always_comb begin
      presc_d = presc_q;
      if (tick_en) presc_d = (presc_q == PS_MAX) ? '0 : presc_q + CNT_W'(1);
      pend_d = pend_q;
      if (tick && seq_done)  pend_d = pend_q;
      else if (tick)         pend_d = pend_sat ? pend_q : pend_q + PEND_W'(1);
      else if (seq_done)     pend_d = pend_q - PEND_W'(1);
   end

   assign s_pready  = (state_q == ST_C_ACCESS) && m_pready;
   assign s_prdata  = s_pready ? m_prdata : 32'd0;
   assign s_pslverr = s_pready && m_pslverr;
   assign tick_drop = tick && pend_sat;
   assign tick_err  = tick_access && m_pready && m_pslverr;

   assign m_psel    = m_psel_q;
   assign m_penable = m_penable_q;
   assign m_paddr   = m_paddr_q;
   assign m_pwrite  = m_pwrite_q;
   assign m_pwdata  = m_pwdata_q;
   assign m_pwstrb  = m_pwstrb_q;

endmodule

// File: tb/tb_mtime_tick_arb.sv
module tb_mtime_tick_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_en;
   logic        s_psel, s_penable, s_pwrite;
   logic [15:0] s_paddr;
   logic [31:0] s_pwdata;
   logic [3:0]  s_pwstrb;
   logic        s_pready, s_pslverr;
   logic [31:0] s_prdata;
   logic        m_psel, m_penable, m_pwrite;
   logic [15:0] m_paddr;
   logic [31:0] m_pwdata;
   logic [3:0]  m_pwstrb;
   logic        m_pready, m_pslverr;
   logic [31:0] m_prdata;
   logic        tick_drop, tick_err;

   int n_run  = 0;
   int n_fail = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   mtime_tick_arb #(.PRESCALE(4), .PEND_W(4), .MTIME_ADDR(16'h0000)) dut (
      .clk(clk), .rst(rst), .tick_en(tick_en),
      .s_psel(s_psel), .s_penable(s_penable), .s_paddr(s_paddr),
      .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pwstrb(s_pwstrb),
      .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
      .m_psel(m_psel), .m_penable(m_penable), .m_paddr(m_paddr),
      .m_pwrite(m_pwrite), .m_pwdata(m_pwdata), .m_pwstrb(m_pwstrb),
      .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
      .tick_drop(tick_drop), .tick_err(tick_err)
   );

   // ---------------- mtimer slave model ----------------
   logic        slv_ready;
   logic        err_wlo;
   logic [31:0] mem_lo, mem_hi, cmp_lo, cmp_hi;
   int          cyc = 0;
   int          err_cnt = 0;
   int          drop_cnt = 0;

   logic [15:0] log_addr[$];
   logic        log_wr[$];
   logic [3:0]  log_strb[$];
   logic [31:0] log_data[$];
   int          log_cyc[$];

   assign m_pready  = slv_ready;
   assign m_pslverr = m_psel && m_penable &&
                      ((err_wlo && m_pwrite && (m_paddr == 16'h0000)) || (m_paddr == 16'h9000));

   always_comb begin
      case (m_paddr)
         16'h0000: m_prdata = mem_lo;
         16'h0004: m_prdata = mem_hi;
         16'h8000: m_prdata = cmp_lo;
         16'h8004: m_prdata = cmp_hi;
         default:  m_prdata = 32'hDEAD_BEEF;
      endcase
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tick_err)  err_cnt  = err_cnt + 1;
      if (tick_drop) drop_cnt = drop_cnt + 1;
      if (m_psel && m_penable && m_pready) begin
         log_addr.push_back(m_paddr);
         log_wr.push_back(m_pwrite);
         log_strb.push_back(m_pwstrb);
         log_data.push_back(m_pwrite ? m_pwdata : m_prdata);
         log_cyc.push_back(cyc);
         if (m_pwrite && !m_pslverr) begin
            case (m_paddr)
               16'h0000: mem_lo = m_pwdata;
               16'h0004: mem_hi = m_pwdata;
               16'h8000: cmp_lo = m_pwdata;
               16'h8004: cmp_hi = m_pwdata;
               default: ;
            endcase
         end
      end
   end

   // {addr, write, strb, data} of logged transfer i, X when absent
   function automatic logic [52:0] log_ent(input int i);
      if (i < log_addr.size()) return {log_addr[i], log_wr[i], log_strb[i], log_data[i]};
      return 'x;
   endfunction

   task automatic clear_log();
      log_addr.delete(); log_wr.delete(); log_strb.delete();
      log_data.delete(); log_cyc.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // lat counts cycles from the cycle s_psel rises (cycle 1) to the s_pready cycle; -1 on timeout
   task automatic cpu_xfer(input logic [15:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic [3:0] strb, output logic [31:0] rdata,
                           output logic err, output int lat);
      bit got = 0;
      s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr;
      s_pwrite = wr; s_pwdata = wdata; s_pwstrb = strb;
      lat = 1; rdata = '0; err = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         step(1);
         s_penable = 1'b1;
         lat++;
         if (s_pready) begin
            rdata = s_prdata; err = s_pslverr; got = 1;
         end
      end
      if (!got) lat = -1;
      step(1);
      s_psel = 1'b0; s_penable = 1'b0;
   endtask

   task automatic tick_burst(input int edges);
      tick_en = 1'b1;
      step(edges);
      tick_en = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(2);
      n_run++;
      if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pwstrb} !== 55'd0) begin
         n_fail++; $display("FAIL reset_m_bus got=%h exp=0", {m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pwstrb});
      end
      n_run++;
      if ({s_pready, s_prdata, s_pslverr, tick_drop, tick_err} !== 36'd0) begin
         n_fail++; $display("FAIL reset_s_flags got=%h exp=0", {s_pready, s_prdata, s_pslverr, tick_drop, tick_err});
      end
      rst = 1'b0;
   endtask

   task automatic test_tick_basic();
      mem_lo = 32'd5; mem_hi = 32'd0; clear_log();
      tick_burst(4);
      step(10);
      n_run++;
      if (log_addr.size() !== 2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", log_addr.size()); end
      n_run++;
      if (log_ent(0) !== {16'h0000, 1'b0, 4'hF, 32'd5}) begin n_fail++; $display("FAIL basic_rlo got=%h exp=%h", log_ent(0), {16'h0000, 1'b0, 4'hF, 32'd5}); end
      n_run++;
      if (log_ent(1) !== {16'h0000, 1'b1, 4'hF, 32'd6}) begin n_fail++; $display("FAIL basic_wlo got=%h exp=%h", log_ent(1), {16'h0000, 1'b1, 4'hF, 32'd6}); end
      n_run++;
      if (mem_lo !== 32'd6) begin n_fail++; $display("FAIL basic_mem got=%h exp=6", mem_lo); end
   endtask

   task automatic test_tick_carry();
      logic [31:0] rd; logic er; int lat;
      mem_lo = 32'hFFFF_FFFF; mem_hi = 32'd7; cmp_lo = 32'h1111_2222; clear_log();
      fork
         tick_burst(4);
         begin step(5); cpu_xfer(16'h8000, 1'b0, 32'd0, 4'h0, rd, er, lat); end
      join
      step(4);
      n_run++;
      if (log_addr.size() !== 5) begin n_fail++; $display("FAIL carry_count got=%0d exp=5", log_addr.size()); end
      n_run++;
      if ({log_ent(0), log_ent(1)} !== {16'h0, 1'b0, 4'hF, 32'hFFFF_FFFF, 16'h0, 1'b1, 4'hF, 32'h0}) begin
         n_fail++; $display("FAIL carry_lo got=%h %h exp=lo read FFFFFFFF then write 0", log_ent(0), log_ent(1));
      end
      n_run++;
      if ({log_ent(2), log_ent(3)} !== {16'h4, 1'b0, 4'hF, 32'd7, 16'h4, 1'b1, 4'hF, 32'd8}) begin
         n_fail++; $display("FAIL carry_hi got=%h %h exp=hi read 7 then write 8", log_ent(2), log_ent(3));
      end
      n_run++;
      if (log_ent(4) !== {16'h8000, 1'b0, 4'h0, 32'h1111_2222}) begin n_fail++; $display("FAIL carry_cpu_after got=%h exp=%h", log_ent(4), {16'h8000, 1'b0, 4'h0, 32'h1111_2222}); end
      n_run++;
      if (log_cyc.size() < 4 || (log_cyc[3] - log_cyc[0]) != 6) begin n_fail++; $display("FAIL carry_atomic got=%0d entries exp=4 accesses over 8 cycles", log_cyc.size()); end
      n_run++;
      if ({mem_hi, mem_lo} !== 64'h8_0000_0000) begin n_fail++; $display("FAIL carry_mem got=%h exp=800000000", {mem_hi, mem_lo}); end
      n_run++;
      if (lat !== 11 || rd !== 32'h1111_2222) begin n_fail++; $display("FAIL carry_cpu_stall got lat=%0d rd=%h exp lat=11 rd=11112222", lat, rd); end
   endtask

   task automatic test_cpu_path();
      logic [31:0] rd; logic er; int lat;
      cmp_hi = 32'hCAFE_0004; clear_log();
      cpu_xfer(16'h8004, 1'b0, 32'd0, 4'h0, rd, er, lat);
      n_run++;
      if ({lat, rd, er} !== {32'd3, 32'hCAFE_0004, 1'b0}) begin n_fail++; $display("FAIL cpu_read got lat=%0d rd=%h err=%b exp lat=3 rd=cafe0004 err=0", lat, rd, er); end
      cpu_xfer(16'h8000, 1'b1, 32'h1234_5678, 4'h5, rd, er, lat);
      n_run++;
      if ({lat, er} !== {32'd3, 1'b0}) begin n_fail++; $display("FAIL cpu_write got lat=%0d err=%b exp lat=3 err=0", lat, er); end
      n_run++;
      if (log_ent(1) !== {16'h8000, 1'b1, 4'h5, 32'h1234_5678} || cmp_lo !== 32'h1234_5678) begin
         n_fail++; $display("FAIL cpu_write_fwd got=%h mem=%h exp=%h", log_ent(1), cmp_lo, {16'h8000, 1'b1, 4'h5, 32'h1234_5678});
      end
      cpu_xfer(16'h9000, 1'b0, 32'd0, 4'h0, rd, er, lat);
      n_run++;
      if ({lat, rd, er} !== {32'd3, 32'hDEAD_BEEF, 1'b1}) begin n_fail++; $display("FAIL cpu_slverr got lat=%0d rd=%h err=%b exp lat=3 rd=deadbeef err=1", lat, rd, er); end
   endtask

   task automatic test_back_to_back_arb();
      logic [31:0] rd; logic er; int lat;
      mem_lo = 32'h100; clear_log();
      fork
         tick_burst(8);
         begin step(4); cpu_xfer(16'h8004, 1'b0, 32'd0, 4'h0, rd, er, lat); end
      join
      step(10);
      n_run++;
      if (log_addr.size() !== 5) begin n_fail++; $display("FAIL arb_count got=%0d exp=5", log_addr.size()); end
      n_run++;
      if ({log_ent(0), log_ent(1)} !== {16'h0, 1'b0, 4'hF, 32'h100, 16'h0, 1'b1, 4'hF, 32'h101}) begin
         n_fail++; $display("FAIL arb_tick_first got=%h %h exp=read 100 write 101", log_ent(0), log_ent(1));
      end
      n_run++;
      if (log_ent(2) !== {16'h8004, 1'b0, 4'h0, 32'hCAFE_0004}) begin n_fail++; $display("FAIL arb_cpu_second got=%h exp=%h", log_ent(2), {16'h8004, 1'b0, 4'h0, 32'hCAFE_0004}); end
      n_run++;
      if ({log_ent(3), log_ent(4)} !== {16'h0, 1'b0, 4'hF, 32'h101, 16'h0, 1'b1, 4'hF, 32'h102}) begin
         n_fail++; $display("FAIL arb_tick_last got=%h %h exp=read 101 write 102", log_ent(3), log_ent(4));
      end
      n_run++;
      if (lat !== 8) begin n_fail++; $display("FAIL arb_cpu_lat got=%0d exp=8", lat); end
   endtask

   task automatic test_slverr_abort();
      mem_lo = 32'hFFFF_FFFF; mem_hi = 32'd3; err_wlo = 1'b1; err_cnt = 0; clear_log();
      tick_burst(4);
      step(12);
      err_wlo = 1'b0;
      n_run++;
      if (err_cnt !== 1) begin n_fail++; $display("FAIL err_pulse got=%0d exp=1", err_cnt); end
      n_run++;
      if (log_addr.size() !== 2 || log_ent(1) !== {16'h0, 1'b1, 4'hF, 32'h0}) begin
         n_fail++; $display("FAIL err_no_rhi got n=%0d last=%h exp n=2 last=write 0 at 0", log_addr.size(), log_ent(1));
      end
      n_run++;
      if ({mem_hi, mem_lo} !== {32'd3, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL err_mem got=%h exp=3ffffffff", {mem_hi, mem_lo}); end
   endtask

   task automatic test_saturate_reset();
      slv_ready = 1'b0; drop_cnt = 0; clear_log();
      tick_en = 1'b1;
      step(60);
      n_run++;
      if (drop_cnt !== 0) begin n_fail++; $display("FAIL sat_early_drop got=%0d exp=0", drop_cnt); end
      step(4);
      tick_en = 1'b0;
      n_run++;
      if (drop_cnt !== 1) begin n_fail++; $display("FAIL sat_drop got=%0d exp=1", drop_cnt); end
      n_run++;
      if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwstrb} !== {1'b1, 1'b1, 16'h0, 1'b0, 4'hF}) begin
         n_fail++; $display("FAIL sat_wait_hold got=%h exp=%h", {m_psel, m_penable, m_paddr, m_pwrite, m_pwstrb}, {1'b1, 1'b1, 16'h0, 1'b0, 4'hF});
      end
      rst = 1'b1;
      #1;
      n_run++;
      if ({m_psel, m_penable, m_paddr, m_pwrite, m_pwdata, m_pwstrb, s_pready, s_prdata, s_pslverr, tick_drop, tick_err} !== 91'd0) begin
         n_fail++; $display("FAIL rst_mid_access got psel=%b pen=%b strb=%h exp all 0", m_psel, m_penable, m_pwstrb);
      end
      slv_ready = 1'b1;
      step(1);
      rst = 1'b0;
      step(12);
      n_run++;
      if (log_addr.size() !== 0) begin n_fail++; $display("FAIL rst_pending_clear got=%0d transfers exp=0", log_addr.size()); end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; tick_en = 1'b0;
      s_psel = 1'b0; s_penable = 1'b0; s_paddr = '0; s_pwrite = 1'b0; s_pwdata = '0; s_pwstrb = '0;
      slv_ready = 1'b1; err_wlo = 1'b0;
      mem_lo = '0; mem_hi = '0; cmp_lo = '0; cmp_hi = '0;
      test_reset();
      test_tick_basic();
      test_tick_carry();
      test_cpu_path();
      test_back_to_back_arb();
      test_slverr_abort();
      test_saturate_reset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
